// File: rtl/mcore_handshake.sv
// rtl/mcore_handshake.sv - hardwired multi-cycle core with byte ROM fetch and req/ack data memory
module mcore_handshake #(
    parameter int DW   = 24,
    parameter int AW   = 24,
    parameter int PCW  = 9,
    parameter int NREG = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    output logic [PCW-1:0] im_addr,
    input  logic [7:0]     im_data,
    output logic           dm_req,
    output logic           dm_we,
    output logic [AW-1:0]  dm_addr,
    output logic [7:0]     dm_wdata,
    input  logic [7:0]     dm_rdata,
    input  logic           dm_ack,
    output logic           finish,
    output logic           illegal,
    output logic           z_flag
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_OPWAIT, S_OPCAP, S_EXEC, S_MEMWAIT, S_HALT
    } state_t;

    state_t          state, state_nx;
    logic [PCW-1:0]  pc;
    logic [DW-1:0]   ac, r, rn;
    logic [DW-1:0]   gpr [NREG];
    logic [7:0]      ir;
    logic            z;
    logic [3:0]      op, n;
    logic            n_ok, uses_reg, bad_op, is_illegal;
    logic [DW-1:0]   ac_add, ac_sub;
    logic [11:0]     jmp_raw;

    assign op       = ir[7:4];
    assign n        = ir[3:0];
    assign n_ok     = {1'b0, n} < 5'(NREG);
    assign uses_reg = (op >= 4'h2) && (op <= 4'h8);
    assign bad_op   = (op >= 4'hB) && (op <= 4'hE);
    assign is_illegal = bad_op || (uses_reg && !n_ok);
    assign ac_add   = ac + rn;
    assign ac_sub   = ac - rn;
    assign jmp_raw  = {n, r[7:0]};

    assign im_addr  = pc;
    assign finish   = (state == S_HALT);
    assign z_flag   = z;

    always_comb begin
        rn = '0;
        for (int i = 0; i < NREG; i++)
            if (n == 4'(i)) rn = gpr[i];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    // Two-byte opcodes are recognised straight off the ROM bus, before IR holds them.
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:   if (enable) state_nx = S_DECODE;
            S_DECODE:  state_nx = (im_data[7:4] == 4'h1 || im_data[7:4] == 4'h9 ||
                                   im_data[7:4] == 4'hA) ? S_OPWAIT : S_EXEC;
            S_OPWAIT:  state_nx = S_OPCAP;
            S_OPCAP:   state_nx = S_EXEC;
            S_EXEC: begin
                if (is_illegal)                      state_nx = S_FETCH;
                else if (op == 4'h7 || op == 4'h8)   state_nx = S_MEMWAIT;
                else if (op == 4'hF)                 state_nx = S_HALT;
                else                                 state_nx = S_FETCH;
            end
            S_MEMWAIT: if (dm_ack) state_nx = S_FETCH;
            S_HALT:    state_nx = S_HALT;
            default:   state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            ac       <= '0;
            r        <= '0;
            ir       <= '0;
            z        <= 1'b0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            illegal  <= 1'b0;
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                S_DECODE: begin
                    ir <= im_data;
                    pc <= pc + PCW'(1);
                end
                S_OPCAP: begin
                    r  <= DW'(im_data);
                    pc <= pc + PCW'(1);
                end
                S_EXEC: begin
                    if (is_illegal) begin
                        illegal <= 1'b1;
                    end else begin
                        case (op)
                            4'h1: begin ac <= r;      z <= (r == '0);      end
                            4'h2: for (int i = 0; i < NREG; i++)
                                      if (n == 4'(i)) gpr[i] <= ac;
                            4'h3: begin ac <= rn;     z <= (rn == '0);     end
                            4'h4: begin ac <= ac_add; z <= (ac_add == '0); end
                            4'h5: begin ac <= ac_sub; z <= (ac_sub == '0); end
                            4'h6: for (int i = 0; i < NREG; i++)
                                      if (n == 4'(i)) gpr[i] <= rn + DW'(1);
                            4'h7, 4'h8: begin
                                dm_req   <= 1'b1;
                                dm_we    <= (op == 4'h8);
                                dm_addr  <= AW'(rn);
                                dm_wdata <= ac[7:0];
                            end
                            4'h9: pc <= PCW'(jmp_raw);
                            4'hA: if (z) pc <= PCW'(jmp_raw);
                            default: ;
                        endcase
                    end
                end
                S_MEMWAIT: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (!dm_we) begin
                            ac <= DW'(dm_rdata);
                            z  <= (dm_rdata == 8'h00);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcore_handshake.sv
// tb/tb_mcore_handshake.sv - directed self-checking bench for mcore_handshake
module tb_mcore_handshake;

    logic        clk, rst, enable;
    logic [8:0]  im_addr;
    logic [7:0]  im_data;
    logic        dm_req, dm_we, dm_ack;
    logic [23:0] dm_addr;
    logic [7:0]  dm_wdata, dm_rdata;
    logic        finish, illegal, z_flag;

    logic [7:0]  rom  [512];
    logic [7:0]  dmem [256];
    int          tests, fails;
    int          ack_delay, wait_cnt, req_cycles, writes;
    logic        resp_en, force_ack;

    mcore_handshake dut (
        .clk(clk), .rst(rst), .enable(enable),
        .im_addr(im_addr), .im_data(im_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .finish(finish), .illegal(illegal), .z_flag(z_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) im_data <= rom[im_addr];

    // Data-memory responder: acks after ack_delay cycles of dm_req, acting at negedge.
    initial begin
        dm_ack = 1'b0; dm_rdata = 8'h00; wait_cnt = 0;
        forever begin
            @(negedge clk);
            dm_ack = force_ack;
            if (force_ack) dm_rdata = 8'hFF;
            if (dm_req === 1'b1 && resp_en) begin
                req_cycles++;
                if (wait_cnt >= ack_delay) begin
                    dm_ack = 1'b1; wait_cnt = 0;
                    dm_rdata = dmem[dm_addr[7:0]];
                    if (dm_we) begin dmem[dm_addr[7:0]] = dm_wdata; writes++; end
                end else wait_cnt++;
            end else wait_cnt = 0;
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic fill_mem;
        for (int i = 0; i < 512; i++) rom[i] = 8'hF0;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h5A;
    endtask

    task automatic do_reset;
        rst = 1'b1; enable = 1'b1; resp_en = 1'b1; force_ack = 1'b0;
        req_cycles = 0; writes = 0;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        fill_mem();
        ack_delay = 0;
        do_reset();
        tests++; if (im_addr !== 9'h000) begin fails++; $display("FAIL rst_im_addr got %h want 000", im_addr); end
        tests++; if (dm_req !== 1'b0 || dm_we !== 1'b0) begin fails++; $display("FAIL rst_dm_ctl got req=%b we=%b want 0 0", dm_req, dm_we); end
        tests++; if (dm_addr !== 24'h0 || dm_wdata !== 8'h0) begin fails++; $display("FAIL rst_dm_data got %h %h want 0 0", dm_addr, dm_wdata); end
        tests++; if (finish !== 1'b0 || illegal !== 1'b0) begin fails++; $display("FAIL rst_flags got fin=%b ill=%b want 0 0", finish, illegal); end
        tests++; if (z_flag !== 1'b0 || dut.ac !== 24'h0) begin fails++; $display("FAIL rst_ac_z got ac=%h z=%b want 0 0", dut.ac, z_flag); end
    endtask

    task automatic test_program;
        logic [8:0] held;
        fill_mem();
        rom[0] = 8'h10; rom[1] = 8'h05; rom[2] = 8'h21;
        rom[3] = 8'h10; rom[4] = 8'h07; rom[5] = 8'h41; rom[6] = 8'hF0;
        do_reset();
        cycles(16);
        tests++; if (dut.ac !== 24'd12) begin fails++; $display("FAIL prog_ac got %h want 00000c", dut.ac); end
        tests++; if (dut.gpr[1] !== 24'd5) begin fails++; $display("FAIL prog_r1 got %h want 000005", dut.gpr[1]); end
        tests++; if (z_flag !== 1'b0 || finish !== 1'b0) begin fails++; $display("FAIL prog_z_fin got z=%b fin=%b want 0 0", z_flag, finish); end
        cycles(3);
        tests++; if (finish !== 1'b1) begin fails++; $display("FAIL prog_finish got %b want 1", finish); end
        held = im_addr;
        tests++; if (held !== 9'd7) begin fails++; $display("FAIL prog_halt_pc got %h want 007", held); end
        cycles(5);
        tests++; if (im_addr !== 9'd7 || finish !== 1'b1 || dm_req !== 1'b0) begin
            fails++; $display("FAIL prog_halt_hold got pc=%h fin=%b req=%b want 007 1 0", im_addr, finish, dm_req); end
    endtask

    task automatic test_jz;
        fill_mem();
        rom[0] = 8'h10; rom[1] = 8'h00; rom[2] = 8'hA1; rom[3] = 8'h23;
        do_reset();
        cycles(10);
        tests++; if (im_addr !== 9'h123 || z_flag !== 1'b1) begin fails++; $display("FAIL jz_taken got pc=%h z=%b want 123 1", im_addr, z_flag); end
        rom[1] = 8'h05;
        do_reset();
        cycles(10);
        tests++; if (im_addr !== 9'h004 || z_flag !== 1'b0) begin fails++; $display("FAIL jz_fall got pc=%h z=%b want 004 0", im_addr, z_flag); end
    endtask

    task automatic test_stm_wait;
        int bound, hi, bad;
        fill_mem();
        rom[0] = 8'h10; rom[1] = 8'hAB; rom[2] = 8'h21;
        rom[3] = 8'h10; rom[4] = 8'h3C; rom[5] = 8'h81; rom[6] = 8'hF0;
        ack_delay = 3;
        do_reset();
        bound = 0;
        while (dm_req !== 1'b1 && bound < 40) begin cycles(1); bound++; end
        tests++; if (dm_req !== 1'b1) begin fails++; $display("FAIL stm_req_timeout got %b want 1", dm_req); end
        hi = 0; bad = 0;
        while (dm_req === 1'b1 && hi < 20) begin
            if (dm_addr !== 24'h0000AB || dm_we !== 1'b1 || dm_wdata !== 8'h3C) bad++;
            hi++;
            cycles(1);
        end
        tests++; if (hi != 4) begin fails++; $display("FAIL stm_req_len got %0d want 4", hi); end
        tests++; if (bad != 0) begin fails++; $display("FAIL stm_fields got %0d bad cycles want 0", bad); end
        cycles(4);
        tests++; if (writes != 1 || dmem[8'hAB] !== 8'h3C) begin
            fails++; $display("FAIL stm_write got writes=%0d mem=%h want 1 3c", writes, dmem[8'hAB]); end
    endtask

    task automatic test_ldm_and_reset;
        fill_mem();
        dmem[8'h10] = 8'h00;
        rom[0] = 8'h10; rom[1] = 8'h10; rom[2] = 8'h22;
        rom[3] = 8'h10; rom[4] = 8'h55; rom[5] = 8'h72; rom[6] = 8'hF0;
        ack_delay = 0;
        do_reset();
        cycles(13);
        tests++; if (dut.ac !== 24'h55 || z_flag !== 1'b0) begin fails++; $display("FAIL ldm_pre got ac=%h z=%b want 55 0", dut.ac, z_flag); end
        cycles(3);
        tests++; if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 24'h10) begin
            fails++; $display("FAIL ldm_req got req=%b we=%b addr=%h want 1 0 10", dm_req, dm_we, dm_addr); end
        cycles(1);
        tests++; if (dut.ac !== 24'h0 || z_flag !== 1'b1 || dm_req !== 1'b0) begin
            fails++; $display("FAIL ldm_done got ac=%h z=%b req=%b want 0 1 0", dut.ac, z_flag, dm_req); end

        fill_mem();
        rom[0] = 8'h10; rom[1] = 8'h33; rom[2] = 8'h20; rom[3] = 8'h70;
        do_reset();
        resp_en = 1'b0;
        cycles(11);
        tests++; if (dm_req !== 1'b1 || dm_addr !== 24'h33) begin fails++; $display("FAIL rstmid_req got req=%b addr=%h want 1 33", dm_req, dm_addr); end
        rst = 1'b1; enable = 1'b0;
        cycles(1);
        tests++; if (dm_req !== 1'b0 || dut.ac !== 24'h0 || dut.gpr[0] !== 24'h0 || im_addr !== 9'h0) begin
            fails++; $display("FAIL rstmid_clear got req=%b ac=%h r0=%h pc=%h want 0 0 0 0", dm_req, dut.ac, dut.gpr[0], im_addr); end
        rst = 1'b0; force_ack = 1'b1;
        cycles(2);
        force_ack = 1'b0;
        cycles(1);
        tests++; if (dut.ac !== 24'h0 || dm_req !== 1'b0 || im_addr !== 9'h0) begin
            fails++; $display("FAIL late_ack got ac=%h req=%b pc=%h want 0 0 0", dut.ac, dm_req, im_addr); end
        enable = 1'b1;
    endtask

    task automatic test_illegal;
        int ill, req, bound;
        logic any_reg;
        fill_mem();
        rom[0] = 8'h10; rom[1] = 8'h77; rom[2] = 8'hB0; rom[3] = 8'h25; rom[4] = 8'hF0;
        ack_delay = 0;
        do_reset();
        ill = 0; req = 0; bound = 0;
        while (finish !== 1'b1 && bound < 40) begin
            cycles(1);
            if (illegal === 1'b1) ill++;
            if (dm_req === 1'b1) req++;
            bound++;
        end
        tests++; if (finish !== 1'b1) begin fails++; $display("FAIL ill_timeout got fin=%b want 1", finish); end
        tests++; if (ill != 2) begin fails++; $display("FAIL ill_pulses got %0d want 2", ill); end
        tests++; if (req != 0) begin fails++; $display("FAIL ill_no_mem got %0d req cycles want 0", req); end
        any_reg = 1'b0;
        for (int i = 0; i < 4; i++) if (dut.gpr[i] !== 24'h0) any_reg = 1'b1;
        tests++; if (any_reg !== 1'b0 || dut.ac !== 24'h77) begin
            fails++; $display("FAIL ill_state got regs_changed=%b ac=%h want 0 77", any_reg, dut.ac); end
    endtask

    task automatic test_enable_wrap;
        fill_mem();
        rom[0] = 8'h60; rom[1] = 8'h50; rom[2] = 8'h40; rom[3] = 8'h91; rom[4] = 8'hFF;
        rom[9'h1FF] = 8'h00;
        do_reset();
        cycles(6);
        tests++; if (dut.ac !== 24'hFFFFFF || z_flag !== 1'b0 || dut.gpr[0] !== 24'h1) begin
            fails++; $display("FAIL sub_wrap got ac=%h z=%b r0=%h want ffffff 0 1", dut.ac, z_flag, dut.gpr[0]); end
        cycles(2);
        enable = 1'b0;
        cycles(4);
        tests++; if (dut.ac !== 24'h0 || z_flag !== 1'b1) begin fails++; $display("FAIL add_wrap got ac=%h z=%b want 0 1", dut.ac, z_flag); end
        tests++; if (im_addr !== 9'h003) begin fails++; $display("FAIL freeze_pc got %h want 003", im_addr); end
        cycles(3);
        tests++; if (im_addr !== 9'h003 || dut.ac !== 24'h0) begin fails++; $display("FAIL freeze_hold got pc=%h ac=%h want 003 0", im_addr, dut.ac); end
        enable = 1'b1;
        cycles(5);
        tests++; if (im_addr !== 9'h1FF) begin fails++; $display("FAIL jmp_target got %h want 1ff", im_addr); end
        cycles(3);
        tests++; if (im_addr !== 9'h000) begin fails++; $display("FAIL pc_wrap got %h want 000", im_addr); end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; enable = 1'b1; resp_en = 1'b1; force_ack = 1'b0;
        ack_delay = 0; req_cycles = 0; writes = 0;
        test_reset();
        test_program();
        test_jz();
        test_stm_wait();
        test_ldm_and_reset();
        test_illegal();
        test_enable_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
